// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for the RV32IM 5-stage core.
// Optional perf counters: define STALL_PERF_COUNTERS_EN.
module pipeline_stall_controller #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_WIDTH      = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LU_HAZARD,
  input  logic        BRANCH_TAKEN_EX,
  input  logic        MULDIV_EX,
  input  logic        DMEM_BUSY,
  output logic        PC_WRITE_EN,
  output logic        IF_ID_WRITE_EN,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_WRITE_EN,
  output logic        ID_EX_BUBBLE,
  output logic        EX_MEM_WRITE_EN,
  output logic        EX_MEM_BUBBLE,
  output logic        MEM_WB_BUBBLE,
  output logic        MULDIV_BUSY
`ifdef STALL_PERF_COUNTERS_EN
  ,
  output logic [31:0] STALL_CYCLES,
  output logic [31:0] LU_STALLS,
  output logic [31:0] MULDIV_STALLS
`endif
);

  typedef enum logic [1:0] {
    RUN,
    MD_BUSY,
    MD_RELEASE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
    CNT_WIDTH'(MULDIV_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  logic md_stall;
  logic rule_rst;
  logic rule_dm;
  logic rule_md;
  logic rule_br;
  logic rule_lu;

  assign md_stall = ((state == RUN) && MULDIV_EX)
                 || (state == MD_BUSY);

  assign rule_rst = RESET;
  assign rule_dm  = !RESET && DMEM_BUSY;
  assign rule_md  = !RESET && !DMEM_BUSY && md_stall;
  assign rule_br  = !RESET && !DMEM_BUSY && !md_stall
                 && BRANCH_TAKEN_EX;
  assign rule_lu  = !RESET && !DMEM_BUSY && !md_stall
                 && !BRANCH_TAKEN_EX && LU_HAZARD;

  assign MULDIV_BUSY = !RESET && (state == MD_BUSY);

  // State and latency counter registers
  always_ff @(posedge CLK) begin
    state <= state_nxt;
    cnt   <= cnt_nxt;
  end

  // Next state; the unit free-runs through memory waits
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (RESET) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (MULDIV_EX && !DMEM_BUSY) begin
            state_nxt = MD_BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
        MD_BUSY: begin
          if (cnt == CNT_ONE) begin
            state_nxt = MD_RELEASE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        MD_RELEASE: begin
          if (!DMEM_BUSY) state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Pipeline register controls, one active rule at a time
  always_comb begin
    PC_WRITE_EN     = 1'b1;
    IF_ID_WRITE_EN  = 1'b1;
    IF_ID_FLUSH     = 1'b0;
    ID_EX_WRITE_EN  = 1'b1;
    ID_EX_BUBBLE    = 1'b0;
    EX_MEM_WRITE_EN = 1'b1;
    EX_MEM_BUBBLE   = 1'b0;
    MEM_WB_BUBBLE   = 1'b0;
    unique case (1'b1)
      rule_rst: begin
        IF_ID_FLUSH   = 1'b1;
        ID_EX_BUBBLE  = 1'b1;
        EX_MEM_BUBBLE = 1'b1;
        MEM_WB_BUBBLE = 1'b1;
      end
      rule_dm: begin
        PC_WRITE_EN     = 1'b0;
        IF_ID_WRITE_EN  = 1'b0;
        ID_EX_WRITE_EN  = 1'b0;
        EX_MEM_WRITE_EN = 1'b0;
        MEM_WB_BUBBLE   = 1'b1;
      end
      rule_md: begin
        PC_WRITE_EN    = 1'b0;
        IF_ID_WRITE_EN = 1'b0;
        ID_EX_WRITE_EN = 1'b0;
        EX_MEM_BUBBLE  = 1'b1;
      end
      rule_br: begin
        IF_ID_FLUSH  = 1'b1;
        ID_EX_BUBBLE = 1'b1;
      end
      rule_lu: begin
        PC_WRITE_EN    = 1'b0;
        IF_ID_WRITE_EN = 1'b0;
        ID_EX_BUBBLE   = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef STALL_PERF_COUNTERS_EN
  // Stall statistics, cleared and frozen by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      STALL_CYCLES  <= '0;
      LU_STALLS     <= '0;
      MULDIV_STALLS <= '0;
    end else begin
      if (!PC_WRITE_EN) STALL_CYCLES <= STALL_CYCLES + 32'd1;
      if (rule_lu) LU_STALLS <= LU_STALLS + 32'd1;
      if (rule_md) MULDIV_STALLS <= MULDIV_STALLS + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: vectors,
// hand sequences, random run against a reference model.
module tb_pipeline_stall_controller;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst, lu, br, md, dm;
  logic pc_en, ifid_en, ifid_fl, idex_en, idex_b;
  logic exmem_en, exmem_b, memwb_b, busy;
`ifdef STALL_PERF_COUNTERS_EN
  logic [31:0] stall_cycles, lu_stalls, md_stalls;
`endif

  logic [8:0] outs;
  assign outs = {pc_en, ifid_en, ifid_fl, idex_en, idex_b,
                 exmem_en, exmem_b, memwb_b, busy};

  pipeline_stall_controller #(
    .MULDIV_LATENCY(LAT),
    .CNT_WIDTH(6)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .LU_HAZARD(lu),
    .BRANCH_TAKEN_EX(br),
    .MULDIV_EX(md),
    .DMEM_BUSY(dm),
    .PC_WRITE_EN(pc_en),
    .IF_ID_WRITE_EN(ifid_en),
    .IF_ID_FLUSH(ifid_fl),
    .ID_EX_WRITE_EN(idex_en),
    .ID_EX_BUBBLE(idex_b),
    .EX_MEM_WRITE_EN(exmem_en),
    .EX_MEM_BUBBLE(exmem_b),
    .MEM_WB_BUBBLE(memwb_b),
    .MULDIV_BUSY(busy)
`ifdef STALL_PERF_COUNTERS_EN
    ,
    .STALL_CYCLES(stall_cycles),
    .LU_STALLS(lu_stalls),
    .MULDIV_STALLS(md_stalls)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [8:0] V_DEF = 9'b110101000;
  localparam logic [8:0] V_RST = 9'b111111110;
  localparam logic [8:0] V_LU  = 9'b000111000;
  localparam logic [8:0] V_BR  = 9'b111111000;
  localparam logic [8:0] V_DM  = 9'b000000010;
  localparam logic [8:0] V_DMB = 9'b000000011;
  localparam logic [8:0] V_MD0 = 9'b000001100;
  localparam logic [8:0] V_MDB = 9'b000001101;

  int checks = 0;
  int failures = 0;

  int md_left = 0;
  bit in_rel = 1'b0;

  function automatic logic [8:0] model_out(
    bit r, bit l, bit b, bit m, bit d);
    bit mbusy;
    bit mstall;
    mbusy  = (md_left > 0);
    mstall = mbusy || (!in_rel && m);
    if (r) return V_RST;
    if (d) return mbusy ? V_DMB : V_DM;
    if (mstall) return mbusy ? V_MDB : V_MD0;
    if (b) return V_BR;
    if (l) return V_LU;
    return V_DEF;
  endfunction

  task automatic model_step(bit r, bit m, bit d);
    if (r) begin
      md_left = 0;
      in_rel  = 1'b0;
    end else if (md_left > 0) begin
      md_left = md_left - 1;
      if (md_left == 0) in_rel = 1'b1;
    end else if (in_rel) begin
      if (!d) in_rel = 1'b0;
    end else if (m && !d) begin
      md_left = LAT - 1;
    end
  endtask

  task automatic chk(string nm, logic [8:0] act,
                     logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step(bit r, bit l, bit b, bit m, bit d,
                      bit use_exp, logic [8:0] exp,
                      string nm);
    logic [8:0] want;
    @(negedge clk);
    rst = r; lu = l; br = b; md = m; dm = d;
    #2;
    want = use_exp ? exp : model_out(r, l, b, m, d);
    chk(nm, outs, want);
    model_step(r, m, d);
  endtask

  typedef struct {
    bit r, l, b, m, d;
    logic [8:0] exp;
    string nm;
  } vec_t;

  vec_t vt[12];

  initial begin
    rst = 1'b1; lu = 1'b0; br = 1'b0; md = 1'b0; dm = 1'b0;

    vt[0]  = '{1,0,0,0,0, V_RST, "reset0"};
    vt[1]  = '{1,1,0,0,1, V_RST, "reset1"};
    vt[2]  = '{0,0,0,0,0, V_DEF, "idle"};
    vt[3]  = '{0,1,0,0,0, V_LU,  "lu"};
    vt[4]  = '{0,0,0,0,0, V_DEF, "lu_after"};
    vt[5]  = '{0,0,1,0,0, V_BR,  "branch"};
    vt[6]  = '{0,1,1,0,0, V_BR,  "branch_lu"};
    vt[7]  = '{0,0,0,0,1, V_DM,  "dmem"};
    vt[8]  = '{0,1,1,0,1, V_DM,  "dmem_mask"};
    vt[9]  = '{0,0,0,1,1, V_DM,  "md_dmem_run"};
    vt[10] = '{0,0,0,0,0, V_DEF, "md_not_loaded"};
    vt[11] = '{0,1,0,0,0, V_LU,  "lu2"};
    for (int i = 0; i < 12; i++)
      step(vt[i].r, vt[i].l, vt[i].b, vt[i].m, vt[i].d,
           1'b1, vt[i].exp, vt[i].nm);

    step(0,0,0,1,0, 1, V_MD0, "md_c0");
    step(0,1,0,1,0, 1, V_MDB, "md_c1_lu_ign");
    step(0,0,0,1,0, 1, V_MDB, "md_c2");
    step(0,0,0,1,0, 1, V_MDB, "md_c3");
    step(0,0,0,1,0, 1, V_DEF, "md_release");
    step(0,0,0,0,0, 1, V_DEF, "md_run");
    step(0,0,0,1,0, 1, V_MD0, "md_b2b");
    step(0,0,0,1,0, 1, V_MDB, "md_b2b_busy");
    step(1,0,0,1,0, 1, V_RST, "md_reset");
    step(0,0,0,0,0, 1, V_DEF, "md_after_reset");
`ifdef STALL_PERF_COUNTERS_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL perf_clear: got %0d want 0",
               stall_cycles);
    end
`endif

    step(0,0,0,1,0, 1, V_MD0, "dmb_c0");
    step(0,0,0,1,0, 1, V_MDB, "dmb_c1");
    step(0,0,0,1,1, 1, V_DMB, "dmb_c2");
    step(0,0,0,1,1, 1, V_DMB, "dmb_c3");
    step(0,0,0,1,1, 1, V_DM,  "dmb_c4");
    step(0,0,0,1,1, 1, V_DM,  "dmb_c5");
    step(0,0,0,1,1, 1, V_DM,  "dmb_c6");
    step(0,0,0,1,0, 1, V_DEF, "dmb_c7_rel");
    step(0,0,0,1,0, 1, V_MD0, "dmb_c8_run");
    step(0,0,0,1,0, 1, V_MDB, "dmb_c9");
    step(1,0,0,0,0, 1, V_RST, "dmb_reset");

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(39) == 0,
           $urandom_range(2) == 0,
           $urandom_range(3) == 0,
           $urandom_range(2) == 0,
           $urandom_range(3) == 0,
           1'b0, 9'd0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the hazard and condition signals produced around the RV32IM 5-stage pipeline: load-use hazard, taken branch/jump in EX, multi-cycle MUL/DIV in EX, and data-memory wait.
- Drives the write-enable and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Holds a small state machine and a latency counter so a MUL/DIV occupies EX for a fixed number of cycles and is not re-triggered when it is released.

Parameters:
- MULDIV_LATENCY, 32, total stall cycles for one MUL/DIV op in EX; legal range 2..63.
- CNT_WIDTH, 6, width of the latency counter; must satisfy 2^CNT_WIDTH > MULDIV_LATENCY.

Ports:
- CLK  input  1  core clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- LU_HAZARD  input  1  load-use hazard between EX (load) and ID.
- BRANCH_TAKEN_EX  input  1  branch/jump resolved taken in EX.
- MULDIV_EX  input  1  instruction in EX is a MUL/DIV-class op.
- DMEM_BUSY  input  1  data memory has not completed the access in MEM.
- PC_WRITE_EN  output  1  PC may update.
- IF_ID_WRITE_EN  output  1  IF/ID may load.
- IF_ID_FLUSH  output  1  IF/ID loads a NOP.
- ID_EX_WRITE_EN  output  1  ID/EX may load.
- ID_EX_BUBBLE  output  1  ID/EX loads a NOP; only effective when ID_EX_WRITE_EN=1.
- EX_MEM_WRITE_EN  output  1  EX/MEM may load.
- EX_MEM_BUBBLE  output  1  EX/MEM loads a NOP.
- MEM_WB_BUBBLE  output  1  MEM/WB loads a NOP.
- MULDIV_BUSY  output  1  high in MD_BUSY state; status only.

Behaviour:
- State machine: RUN, MD_BUSY, MD_RELEASE. The counter is CNT_WIDTH bits.
- Outputs are combinational from state and inputs. State and counter are registered.
- Reset: while RESET=1, next state is RUN and the counter is 0. Outputs during reset:
  - all *_WRITE_EN = 1
  - IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, MEM_WB_BUBBLE = 1 (pipe filled with NOPs)
  - MULDIV_BUSY = 0
  - RESET mid-MUL/DIV aborts immediately.
- Default when no condition is active: all enables 1, all bubbles/flush 0.
- Priority, highest first:
  1. DMEM_BUSY=1 (any state):
     - PC, IF_ID, ID_EX and EX_MEM enables = 0
     - MEM_WB_BUBBLE = 1
     - all other requests are masked for that cycle
     - the counter still decrements (functional unit free-runs)
     - the state still advances, except MD_RELEASE, which holds until a non-busy cycle.
  2. MUL/DIV stall, asserted when (RUN and MULDIV_EX) or state=MD_BUSY:
     - PC, IF_ID and ID_EX enables = 0
     - EX_MEM_BUBBLE = 1
     - LU_HAZARD is ignored.
  3. BRANCH_TAKEN_EX=1:
     - PC_WRITE_EN = 1
     - IF_ID_FLUSH = 1
     - ID_EX_BUBBLE = 1
     - overrides LU_HAZARD.
  4. LU_HAZARD=1:
     - PC_WRITE_EN = 0, IF_ID_WRITE_EN = 0
     - ID_EX_BUBBLE = 1
     - exactly one bubble per assertion cycle.
- Transitions:
  - RUN & MULDIV_EX & !DMEM_BUSY → MD_BUSY; counter ← MULDIV_LATENCY-1.
  - RUN & MULDIV_EX & DMEM_BUSY → stay in RUN; no load.
  - MD_BUSY: if counter==1 → MD_RELEASE; else counter ← counter-1.
  - MD_RELEASE: MULDIV_EX is ignored; no MUL/DIV stall; → RUN on the first cycle with DMEM_BUSY=0.
- Latency: a MUL/DIV accepted in cycle t stalls cycles t .. t+MULDIV_LATENCY-1 inclusive (MULDIV_LATENCY cycles). In cycle t+MULDIV_LATENCY the op advances to MEM.
- Back-to-back MUL/DIV: the second op reaches EX in the cycle after MD_RELEASE (state is RUN) and triggers normally.
- MULDIV_BUSY = 1 only in MD_BUSY.

Optional Feature:
- Macro: STALL_PERF_COUNTERS_EN.
- When defined, adds three 32-bit outputs:
  - STALL_CYCLES: counts cycles with PC_WRITE_EN=0.
  - LU_STALLS: counts cycles where the load-use rule is the active one.
  - MULDIV_STALLS: counts MUL/DIV stall cycles.
- Counters clear on RESET, wrap at 2^32, and do not count while RESET=1.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: RESET=1 for 2 cycles → every *_WRITE_EN=1, all bubbles/flush=1. Release → default outputs; state RUN.
- Load-use: LU_HAZARD=1 for 1 cycle → PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1 in that cycle only; next cycle defaults.
- MUL/DIV, MULDIV_LATENCY=4: MULDIV_EX held high from cycle 10 →
  - PC_WRITE_EN=0 and EX_MEM_BUBBLE=1 in cycles 10-13
  - MULDIV_BUSY=1 in cycles 11-13
  - cycle 14 (MD_RELEASE) has no stall despite MULDIV_EX=1
  - cycle 15 state RUN.
- Branch+load-use in the same cycle: BRANCH_TAKEN_EX=1, LU_HAZARD=1 → PC_WRITE_EN=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1.
- DMEM_BUSY during MD_BUSY, latency 4 (start cycle 10, DMEM_BUSY cycles 12-16):
  - all front enables=0, MEM_WB_BUBBLE=1 in cycles 12-16
  - counter still reaches MD_RELEASE at cycle 14
  - state held in MD_RELEASE until cycle 17, then RUN.
- RESET asserted in MD_BUSY (cycle 11 of a latency-32 op) → next cycle state RUN, MULDIV_BUSY=0. With STALL_PERF_COUNTERS_EN, STALL_CYCLES=0.
